key_expansion: RTL and testbench

- Sequential AES-128 key schedule, one 32-bit word per cycle.
- Takes a 128-bit cipher key and produces all 11 round keys as one 1408-bit bus.
- Sits directly upstream of the round datapath, which indexes the bus by round number.
- Key_valid tells the round controller when the full schedule is stable.

---
 rtl/key_expansion.sv | 123 ++++++++++++
 tb/tb_key_expansion.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// AES-128 key schedule: expands a 128-bit cipher key into 44 words, one word per clock,
// and presents all 11 round keys on a single bus with round key r at [128*r+127:128*r].
module key_expansion (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [127:0]  key_in,
   output logic [1407:0] round_keys,
   output logic          busy,
   output logic          key_valid
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXPAND = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   logic [1:0]    r_state;
   logic [5:0]    r_cnt;
   logic [127:0]  r_win;
   logic [1407:0] r_keys;
   logic          r_busy;
   logic          r_valid;

   logic [31:0]   w_prev;
   logic [31:0]   w_rot;
   logic [31:0]   w_sub;
   logic [31:0]   w_temp;
   logic [31:0]   w_new;
   logic [7:0]    w_rcon;
   logic [10:0]   w_base;

   always_comb begin
      w_rcon = 8'h00;
      case (r_cnt[5:2])
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   // r_win holds w[i-4]..w[i-1], so the recurrence never needs a read mux on the big bus.
   always_comb begin
      w_prev = r_win[31:0];
      w_rot  = {w_prev[23:0], w_prev[31:24]};
      w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
      w_temp = (r_cnt[1:0] == 2'b00) ? (w_sub ^ {w_rcon, 24'h000000}) : w_prev;
      w_new  = r_win[127:96] ^ w_temp;
      w_base = {r_cnt[5:2], ~r_cnt[1:0], 5'b00000};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_win   <= 128'h0;
         r_keys  <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_keys[127:0] <= key_in;
                  r_win         <= key_in;
                  r_cnt         <= 6'd4;
                  r_busy        <= 1'b1;
                  r_valid       <= 1'b0;
                  r_state       <= S_EXPAND;
               end
            end
            S_EXPAND: begin
               r_keys[w_base +: 32] <= w_new;
               r_win                <= {r_win[95:0], w_new};
               if (r_cnt == 6'd43) begin
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign round_keys = r_keys;
   assign busy       = r_busy;
   assign key_valid  = r_valid;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: table vectors, random keys against a GF(2^8)
// reference model, and hand-written sequences for restart, ignored start and mid-run reset.
module tb_key_expansion;

   logic          clk;
   logic          rst;
   logic          start;
   logic [127:0]  key_in;
   logic [1407:0] round_keys;
   logic          busy;
   logic          key_valid;

   int total = 0;
   int bad   = 0;

   key_expansion dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .round_keys (round_keys),
      .busy       (busy),
      .key_valid  (key_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      logic [127:0] rk1;
      logic [127:0] rk10;
   } vec_t;

   // Reference model: S-box from field inversion plus affine map, not from a table.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sboxRef(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [1407:0] expandRef(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1407:0] out = '0;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sboxRef(t[31:24]), sboxRef(t[23:16]), sboxRef(t[15:8]), sboxRef(t[7:0])};
            t = t ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) out[128*(i/4) + 127 - 32*(i%4) -: 32] = w[i];
      return out;
   endfunction

   task automatic checkOutput(input string name, input logic [1407:0] act, input logic [1407:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulses start with 'key'; optionally re-pulses start with injectKey after injectAt cycles.
   task automatic applyStimulus(input logic [127:0] key, input int injectAt,
                                input logic [127:0] injectKey,
                                output int latency, output logic busyAtStart,
                                output logic validAtStart, output logic busyCont);
      int n = 0;
      @(negedge clk);
      key_in = key;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      key_in       = ~key;
      busyAtStart  = busy;
      validAtStart = key_valid;
      busyCont     = 1'b1;
      while (!key_valid && n < 60) begin
         if (n < 40 && !busy) busyCont = 1'b0;
         if (n == injectAt) begin
            key_in = injectKey;
            start  = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
      end
      if (busy) busyCont = 1'b0;
      latency = n;
   endtask

   vec_t          vecs [2];
   logic [1407:0] exp;
   logic [127:0]  rk;
   int            lat;
   logic          bStart, vStart, bCont;
   int            idleBad;

   initial begin
      vecs[0] = '{key:  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  rk1:  128'ha0fafe1788542cb123a339392a6c7605,
                  rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{key:  128'h0,
                  rk1:  128'h62636363626363636263636362636363,
                  rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      rst    = 1'b0;
      start  = 1'b0;
      key_in = 128'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      idleBad = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (round_keys !== '0 || busy !== 1'b0 || key_valid !== 1'b0) idleBad++;
      end
      checkOutput("idle_after_reset_bad_cycles", 1408'(idleBad), 1408'(0));

      // FIPS run then zero key straight from DONE exercises the back-to-back restart.
      for (int v = 0; v < 2; v++) begin
         applyStimulus(vecs[v].key, -1, 128'h0, lat, bStart, vStart, bCont);
         checkOutput($sformatf("vec%0d_latency", v), 1408'(lat), 1408'(40));
         checkOutput($sformatf("vec%0d_busy_at_start", v), 1408'(bStart), 1408'(1));
         checkOutput($sformatf("vec%0d_valid_drops", v), 1408'(vStart), 1408'(0));
         checkOutput($sformatf("vec%0d_busy_continuous", v), 1408'(bCont), 1408'(1));
         rk = round_keys[127:0];
         checkOutput($sformatf("vec%0d_rk0", v), 1408'(rk), 1408'(vecs[v].key));
         rk = round_keys[255:128];
         checkOutput($sformatf("vec%0d_rk1", v), 1408'(rk), 1408'(vecs[v].rk1));
         rk = round_keys[1407:1280];
         checkOutput($sformatf("vec%0d_rk10", v), 1408'(rk), 1408'(vecs[v].rk10));
         checkOutput($sformatf("vec%0d_full", v), round_keys, expandRef(vecs[v].key));
      end

      for (int r = 0; r < 4; r++) begin
         logic [127:0] k;
         k = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(k, -1, 128'h0, lat, bStart, vStart, bCont);
         checkOutput($sformatf("rand%0d_latency", r), 1408'(lat), 1408'(40));
         checkOutput($sformatf("rand%0d_full", r), round_keys, expandRef(k));
      end

      // start during EXPAND with a different key must be ignored.
      applyStimulus(vecs[0].key, 20, 128'hdeadbeef0123456789abcdef55aa33cc, lat, bStart, vStart, bCont);
      checkOutput("ignore_latency", 1408'(lat), 1408'(40));
      checkOutput("ignore_busy_continuous", 1408'(bCont), 1408'(1));
      checkOutput("ignore_full", round_keys, expandRef(vecs[0].key));
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ignore_no_restart", 1408'({busy, key_valid}), 1408'(2'b01));

      // Asynchronous reset mid-expansion, checked before the next clock edge.
      @(negedge clk);
      key_in = vecs[1].key;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (25) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checkOutput("reset_mid_keys", round_keys, '0);
      checkOutput("reset_mid_busy", 1408'(busy), 1408'(0));
      checkOutput("reset_mid_valid", 1408'(key_valid), 1408'(0));
      @(posedge clk);
      #1 rst = 1'b1;

      applyStimulus(vecs[0].key, -1, 128'h0, lat, bStart, vStart, bCont);
      checkOutput("post_reset_latency", 1408'(lat), 1408'(40));
      rk = round_keys[255:128];
      checkOutput("post_reset_rk1", 1408'(rk), 1408'(vecs[0].rk1));
      rk = round_keys[1407:1280];
      checkOutput("post_reset_rk10", 1408'(rk), 1408'(vecs[0].rk10));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
